// File: rtl/stopwatch_seq_pkg.sv
// Shared stopwatch definitions: controller state encoding, default lap depth
// and the lap entry layout used by the sequencer, lap buffer and datapath status.
package stopwatch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } sw_state_t;

    localparam int LAP_DEPTH_DEFAULT = 4;
    localparam int MIN_W             = 8;
    localparam int SEC_W             = 6;
    localparam int LAP_W             = MIN_W + SEC_W;

    typedef struct packed {
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
    } lap_entry_t;

endpackage

// File: rtl/stopwatch_seq_lap_fifo.sv
// Lap-time FIFO: power-of-two depth, flush beats pop, a push into a full
// buffer is accepted only when a pop frees a slot in the same cycle.
module lap_fifo
    import stopwatch_seq_pkg::*;
#(
    parameter int DEPTH = LAP_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [LAP_W-1:0]         wr_data,
    output logic [LAP_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

    lap_entry_t    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against occupancy; a same-cycle pop makes room for a push.
    always_comb begin
        pop_ok_s  = pop & (count_r != CNT_ZERO);
        push_ok_s = push & ((count_r != CNT_FULL) | pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == CNT_ZERO);

endmodule

// File: rtl/stopwatch_seq.sv
// Stopwatch controller: button edge detection, IDLE/RUNNING/PAUSED FSM with
// one-cycle datapath command pulses, and lap capture into a FIFO.
module stopwatch_seq
    import stopwatch_seq_pkg::*;
#(
    parameter int LAP_DEPTH = LAP_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_ss,
    input  logic                         btn_lap,
    input  logic [7:0]                   cur_minutes,
    input  logic [5:0]                   cur_seconds,
    output logic                         sw_start,
    output logic                         sw_stop,
    output logic                         sw_reset,
    output logic [1:0]                   state,
    output logic                         lap_valid,
    input  logic                         lap_ready,
    output logic [7:0]                   lap_minutes,
    output logic [5:0]                   lap_seconds,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overflow
);

    sw_state_t  state_r;
    logic       ss_prev_r;
    logic       lap_prev_r;
    logic       sw_start_r;
    logic       sw_stop_r;
    logic       sw_reset_r;
    logic       overflow_r;

    logic       ss_rise_s;
    logic       lap_rise_s;
    logic       push_s;
    logic       pop_s;
    logic       flush_s;
    logic       drop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [LAP_W-1:0] head_s;
    lap_entry_t head_entry_s;
    lap_entry_t cur_entry_s;

    assign ss_rise_s  = btn_ss & ~ss_prev_r;
    assign lap_rise_s = btn_lap & ~lap_prev_r;

    // Lap button action depends on state; a start/stop rise swallows it.
    always_comb begin
        push_s  = 1'b0;
        flush_s = 1'b0;
        if (lap_rise_s && !ss_rise_s) begin
            case (state_r)
                ST_RUNNING: push_s  = 1'b1;
                ST_PAUSED:  flush_s = 1'b1;
                default: begin
                    push_s  = 1'b0;
                    flush_s = 1'b0;
                end
            endcase
        end else begin
            push_s  = 1'b0;
            flush_s = 1'b0;
        end
    end

    assign pop_s  = ~fifo_empty_s & lap_ready;
    assign drop_s = push_s & fifo_full_s & ~pop_s;

    // Controller FSM, edge history, command pulses and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ss_prev_r  <= 1'b1;
            lap_prev_r <= 1'b1;
            sw_start_r <= 1'b0;
            sw_stop_r  <= 1'b0;
            sw_reset_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            ss_prev_r  <= btn_ss;
            lap_prev_r <= btn_lap;
            sw_start_r <= 1'b0;
            sw_stop_r  <= 1'b0;
            sw_reset_r <= 1'b0;
            if (flush_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (ss_rise_s) begin
                case (state_r)
                    ST_IDLE: begin
                        sw_start_r <= 1'b1;
                        state_r    <= ST_RUNNING;
                    end
                    ST_RUNNING: begin
                        sw_stop_r <= 1'b1;
                        state_r   <= ST_PAUSED;
                    end
                    ST_PAUSED: begin
                        sw_start_r <= 1'b1;
                        state_r    <= ST_RUNNING;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (flush_s) begin
                sw_reset_r <= 1'b1;
                state_r    <= ST_IDLE;
            end
        end
    end

    assign cur_entry_s = '{minutes: cur_minutes, seconds: cur_seconds};

    lap_fifo #(
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .wr_data (cur_entry_s),
        .rd_data (head_s),
        .count   (lap_count),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign head_entry_s = head_s;
    assign sw_start     = sw_start_r;
    assign sw_stop      = sw_stop_r;
    assign sw_reset     = sw_reset_r;
    assign state        = state_r;
    assign lap_valid    = ~fifo_empty_s;
    assign lap_minutes  = head_entry_s.minutes;
    assign lap_seconds  = head_entry_s.seconds;
    assign lap_overflow = overflow_r;

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq with hand-computed expectations.
module tb_stopwatch_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lap;
    logic [7:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       sw_start;
    logic       sw_stop;
    logic       sw_reset;
    logic [1:0] state;
    logic       lap_valid;
    logic       lap_ready;
    logic [7:0] lap_minutes;
    logic [5:0] lap_seconds;
    logic [2:0] lap_count;
    logic       lap_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_seq #(.LAP_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_ss       (btn_ss),
        .btn_lap      (btn_lap),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .sw_start     (sw_start),
        .sw_stop      (sw_stop),
        .sw_reset     (sw_reset),
        .state        (state),
        .lap_valid    (lap_valid),
        .lap_ready    (lap_ready),
        .lap_minutes  (lap_minutes),
        .lap_seconds  (lap_seconds),
        .lap_count    (lap_count),
        .lap_overflow (lap_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_sw(input string tag, input int s, input int t, input int r);
        check_val({tag, ".sw_start"}, sw_start, s);
        check_val({tag, ".sw_stop"},  sw_stop,  t);
        check_val({tag, ".sw_reset"}, sw_reset, r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_lap(input int m, input int s);
        cur_minutes = 8'(m);
        cur_seconds = 6'(s);
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
        step();
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        step();
        btn_ss = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; lap_ready = 1'b0;
        cur_minutes = 8'd0; cur_seconds = 6'd0;
        step(); step();
        rst = 1'b0;
        step();
        check_val("rst.state", state, 0);
        check_sw("rst", 0, 0, 0);
        check_val("rst.count", lap_count, 0);
        check_val("rst.valid", lap_valid, 0);
        check_val("rst.ovf", lap_overflow, 0);

        // lap in IDLE is ignored
        btn_lap = 1'b1; step();
        check_val("idle_lap.state", state, 0);
        check_val("idle_lap.count", lap_count, 0);
        check_sw("idle_lap", 0, 0, 0);
        btn_lap = 1'b0; step();

        // start, held button gives one action
        btn_ss = 1'b1; step();
        check_sw("start", 1, 0, 0);
        check_val("start.state", state, 1);
        step();
        check_sw("held", 0, 0, 0);
        check_val("held.state", state, 1);
        btn_ss = 1'b0; step();

        btn_ss = 1'b1; step();
        check_sw("stop", 0, 1, 0);
        check_val("stop.state", state, 2);
        btn_ss = 1'b0; step();

        btn_ss = 1'b1; step();
        check_sw("resume", 1, 0, 0);
        check_val("resume.state", state, 1);
        btn_ss = 1'b0; step();

        // single lap 3:07 then pop
        cur_minutes = 8'd3; cur_seconds = 6'd7; btn_lap = 1'b1; step();
        check_sw("lap1", 0, 0, 0);
        check_val("lap1.valid", lap_valid, 1);
        check_val("lap1.min", lap_minutes, 3);
        check_val("lap1.sec", lap_seconds, 7);
        check_val("lap1.count", lap_count, 1);
        check_val("lap1.state", state, 1);
        btn_lap = 1'b0; step();
        lap_ready = 1'b1; step();
        lap_ready = 1'b0;
        check_val("pop1.count", lap_count, 0);
        check_val("pop1.valid", lap_valid, 0);

        // overflow: five captures into four slots
        for (int i = 1; i <= 4; i++) press_lap(0, i);
        check_val("fill.count", lap_count, 4);
        check_val("fill.ovf", lap_overflow, 0);
        press_lap(0, 5);
        check_val("ovf.count", lap_count, 4);
        check_val("ovf.ovf", lap_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check_val("drain.min", lap_minutes, 0);
            check_val("drain.sec", lap_seconds, i);
            lap_ready = 1'b1; step();
            lap_ready = 1'b0;
        end
        check_val("drain.count", lap_count, 0);
        check_val("drain.ovf", lap_overflow, 1);

        // capture and pop together while full
        for (int i = 10; i <= 13; i++) press_lap(1, i);
        cur_minutes = 8'd1; cur_seconds = 6'd14;
        btn_lap = 1'b1; lap_ready = 1'b1; step();
        btn_lap = 1'b0; lap_ready = 1'b0;
        check_val("fullpop.count", lap_count, 4);
        check_val("fullpop.sec", lap_seconds, 11);
        step();
        for (int i = 11; i <= 14; i++) begin
            check_val("drain2.min", lap_minutes, 1);
            check_val("drain2.sec", lap_seconds, i);
            lap_ready = 1'b1; step();
            lap_ready = 1'b0;
        end
        check_val("drain2.count", lap_count, 0);

        // paused flush with pop pending
        press_lap(2, 1);
        press_lap(2, 2);
        check_val("pre_flush.count", lap_count, 2);
        btn_ss = 1'b1; step();
        check_sw("pause", 0, 1, 0);
        btn_ss = 1'b0; step();
        btn_lap = 1'b1; lap_ready = 1'b1; step();
        check_sw("flush", 0, 0, 1);
        check_val("flush.state", state, 0);
        check_val("flush.count", lap_count, 0);
        check_val("flush.ovf", lap_overflow, 0);
        check_val("flush.valid", lap_valid, 0);
        btn_lap = 1'b0; lap_ready = 1'b0; step();
        check_sw("post_flush", 0, 0, 0);

        // simultaneous rises: ss wins
        press_ss();
        check_val("restart.state", state, 1);
        press_lap(4, 4);
        btn_ss = 1'b1; btn_lap = 1'b1; step();
        check_sw("both_run", 0, 1, 0);
        check_val("both_run.state", state, 2);
        check_val("both_run.count", lap_count, 1);
        btn_ss = 1'b0; btn_lap = 1'b0; step();
        btn_ss = 1'b1; btn_lap = 1'b1; step();
        check_sw("both_pause", 1, 0, 0);
        check_val("both_pause.state", state, 1);
        check_val("both_pause.count", lap_count, 1);
        btn_ss = 1'b0; btn_lap = 1'b0; step();

        // reset mid-run with ss rising and held through deassertion
        rst = 1'b1; btn_ss = 1'b1; step();
        check_sw("midrst", 0, 0, 0);
        check_val("midrst.state", state, 0);
        check_val("midrst.count", lap_count, 0);
        step();
        rst = 1'b0; step();
        check_sw("held_rst", 0, 0, 0);
        check_val("held_rst.state", state, 0);
        step();
        check_sw("held_rst2", 0, 0, 0);
        btn_ss = 1'b0; step();
        btn_ss = 1'b1; step();
        check_sw("repress", 1, 0, 0);
        check_val("repress.state", state, 1);
        step();
        check_sw("repress_held", 0, 0, 0);
        btn_ss = 1'b0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_seq.md
STOPWATCH_SEQ -- requirements
Module: stopwatch_seq

Interface
REQ-001 Parameter LAP_DEPTH, default 4: number of lap-time entries held; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 btn_ss  in  1  start/stop button level, pre-debounced and synchronous to clk.
REQ-005 btn_lap  in  1  lap/reset button level, pre-debounced and synchronous to clk.
REQ-006 cur_minutes  in  8  live minutes from the stopwatch datapath.
REQ-007 cur_seconds  in  6  live seconds from the stopwatch datapath, 0..59.
REQ-008 sw_start  out  1  one-cycle start pulse to the datapath.
REQ-009 sw_stop  out  1  one-cycle stop pulse to the datapath.
REQ-010 sw_reset  out  1  one-cycle reset pulse to the datapath.
REQ-011 state  out  2  controller state: 00 IDLE, 01 RUNNING, 10 PAUSED; 11 unused.
REQ-012 lap_valid  out  1  lap buffer non-empty; head entry is presented.
REQ-013 lap_ready  in  1  consumer accepts the head entry.
REQ-014 lap_minutes  out  8  head entry minutes; value is don't-care when lap_valid=0.
REQ-015 lap_seconds  out  6  head entry seconds; value is don't-care when lap_valid=0.
REQ-016 lap_count  out  clog2(LAP_DEPTH)+1  number of stored entries, 0..LAP_DEPTH.
REQ-017 lap_overflow  out  1  sticky flag: a lap capture was dropped.

Function
REQ-018 Each button SHALL be edge-detected with a one-register history: rise = btn & ~btn_prev.
REQ-019 All sw_* outputs SHALL be registered and asserted for exactly one cycle, in the cycle after the clk edge at which the rise is sampled (latency 1).
REQ-020 IDLE + ss rise -> sw_start, go to RUNNING.
REQ-021 RUNNING + ss rise -> sw_stop, go to PAUSED.
REQ-022 PAUSED + ss rise -> sw_start, go to RUNNING.
REQ-023 RUNNING + lap rise -> capture {cur_minutes, cur_seconds} sampled at that edge into the lap buffer; state unchanged; no sw_* pulse.
REQ-024 PAUSED + lap rise -> sw_reset, flush the lap buffer (count=0), clear lap_overflow, go to IDLE.
REQ-025 IDLE + lap rise SHALL be ignored.
REQ-026 Simultaneous ss and lap rise: ss SHALL take priority and the lap rise SHALL be discarded.
REQ-027 A held button SHALL produce one action only; release-and-press is required for another.
REQ-028 At most one sw_* output SHALL be high in any cycle.
REQ-029 Lap buffer SHALL be FIFO-ordered; a pop occurs when lap_valid & lap_ready at a clk edge, and lap_* SHALL show the next entry the following cycle.
REQ-030 Capture while full with no pop: entry SHALL be dropped, contents preserved, lap_overflow set to 1.
REQ-031 Capture and pop in the same cycle while full: both SHALL be accepted, and count is unchanged.
REQ-032 Capture into an empty buffer SHALL give lap_valid=1 in the next cycle (no bypass).
REQ-033 Flush coincident with a pop: flush SHALL win, giving count=0.
REQ-034 lap_overflow SHALL clear only on flush or rst.
REQ-035 Pointers SHALL wrap modulo LAP_DEPTH.

Reset
REQ-036 rst SHALL set state=IDLE, sw_*=0, lap_count=0, lap_valid=0, lap_overflow=0, and both btn_prev registers to 1.
REQ-037 Because btn_prev resets to 1, a button already held during reset SHALL NOT trigger an action.
REQ-038 rst mid-operation SHALL discard buffered laps, take priority over every other input, and SHALL NOT emit sw_reset.

Structure
REQ-039 State encodings (IDLE/RUNNING/PAUSED) and the default LAP_DEPTH SHALL live in the shared stopwatch definitions header, which the datapath status encoding also uses.
REQ-040 The lap buffer SHALL be a separate sub-module, lap_fifo, with push/pop/flush, count and full/empty outputs; stopwatch_seq holds the FSM and edge detection.

Verification
REQ-041 Reset, then ss pulse -> sw_start one cycle after sampling, state=01; second ss pulse -> sw_stop, state=10.
REQ-042 RUNNING, cur=3:07, lap press -> lap_valid=1 next cycle, lap_minutes=3, lap_seconds=7, lap_count=1; lap_ready=1 for one cycle -> lap_count=0.
REQ-043 RUNNING, 5 lap presses (cur 0:01..0:05), lap_ready=0 -> lap_count=4, lap_overflow=1; reads return 0:01, 0:02, 0:03, 0:04.
REQ-044 PAUSED with 2 entries and overflow=1, lap press -> sw_reset pulse, state=00, lap_count=0, lap_overflow=0.
REQ-045 btn_ss and btn_lap rise in the same cycle while RUNNING -> sw_stop only, state=10, lap_count unchanged.
REQ-046 btn_ss held high across rst deassertion -> no sw_start; release then press -> sw_start once.
